// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, falling-edge registered strobes and latch-gated shift clocks.
// Optional debug port tap_state[3:0] is compiled in only when TAP_STATE_DEBUG_EN is defined.
module tap_controller (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output logic       tl_reset,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateIR,
    output logic       updateDR,
    output logic       tck_ir,
    output logic       tck_dr,
    output logic       select,
    output logic       tdo_en
`ifdef TAP_STATE_DEBUG_EN
    ,
    output logic [3:0] tap_state
`endif
);

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    tap_state_e state_q;
    tap_state_e state_d;

    logic tl_reset_q;
    logic tl_reset_d;
    logic select_q;
    logic select_d;
    logic tdo_en_q;
    logic tdo_en_d;
    logic update_ir_q;
    logic update_ir_d;
    logic update_dr_q;
    logic update_dr_d;

    logic en_ir_d;
    logic en_dr_d;
    logic en_ir_l;
    logic en_dr_l;

    // Next-state logic: the standard 1149.1 transition graph.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign captureIR = (state_q == CAP_IR);
    assign shiftIR   = (state_q == SH_IR);
    assign captureDR = (state_q == CAP_DR);
    assign shiftDR   = (state_q == SH_DR);

    // Values presented at the falling edge, so each output is stable across the next rising edge.
    always_comb begin
        tl_reset_d  = (state_q != TLR);
        tdo_en_d    = (state_q == SH_IR) || (state_q == SH_DR);
        update_ir_d = (state_q == UPD_IR);
        update_dr_d = (state_q == UPD_DR);
        select_d    = 1'b0;
        case (state_q)
            SEL_IR, CAP_IR, SH_IR, EX1_IR,
            PAUSE_IR, EX2_IR, UPD_IR: select_d = 1'b1;
            default:                  select_d = 1'b0;
        endcase
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tl_reset_q  <= 1'b0;
            select_q    <= 1'b0;
            tdo_en_q    <= 1'b0;
            update_ir_q <= 1'b0;
            update_dr_q <= 1'b0;
        end else begin
            tl_reset_q  <= tl_reset_d;
            select_q    <= select_d;
            tdo_en_q    <= tdo_en_d;
            update_ir_q <= update_ir_d;
            update_dr_q <= update_dr_d;
        end
    end

    assign tl_reset = tl_reset_q;
    assign select   = select_q;
    assign tdo_en   = tdo_en_q;
    assign updateIR = update_ir_q;
    assign updateDR = update_dr_q;

    always_comb begin
        en_ir_d = (state_q == CAP_IR) || (state_q == SH_IR);
        en_dr_d = (state_q == CAP_DR) || (state_q == SH_DR);
    end

    // Enables only change while tck is low, so the AND below cannot produce a runt pulse.
    always_latch begin
        if (!trst) begin
            en_ir_l <= 1'b0;
            en_dr_l <= 1'b0;
        end else if (!tck) begin
            en_ir_l <= en_ir_d;
            en_dr_l <= en_dr_d;
        end
    end

    assign tck_ir = tck & en_ir_l;
    assign tck_dr = tck & en_dr_l;

`ifdef TAP_STATE_DEBUG_EN
    assign tap_state = state_q;
`endif

endmodule
